// File: rtl/multi_mode_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_mode_queue_pkg
// Purpose  : Shared definitions for the multi-mode queue: build-time mode
//            codes, pointer-width helper and the transfer-kind encoding used
//            by the occupancy counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multi_mode_queue_pkg;

  // Build-time queue modes
  localparam int QUEUE_NORMAL      = 0;
  localparam int QUEUE_PIPE        = 1;
  localparam int QUEUE_BYPASS      = 2;
  localparam int QUEUE_PIPE_BYPASS = 3;

  // Pointer width for a queue of the given depth. A single-entry queue still
  // gets a 1-bit pointer (held at zero) so that no zero-width vectors appear.
  function automatic int ptr_nbits(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // What happened to the stored contents in one cycle
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_DEQ  = 2'b01,
    XFER_ENQ  = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

endpackage
`default_nettype wire

// File: rtl/multi_mode_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_mode_queue_if
// Purpose  : Latency-insensitive val/rdy message stream.
// Ports    : val - producer has a message
//            rdy - consumer can accept a message
//            msg - message payload (p_msg_nbits wide)
//            master modport: producer side (drives val/msg, sees rdy)
//            slave  modport: consumer side (drives rdy, sees val/msg)
// Revision : 1.0 - initial release
// ============================================================================
interface multi_mode_queue_if #(
  parameter int p_msg_nbits = 32
);

  logic                   val;
  logic                   rdy;
  logic [p_msg_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);

endinterface
`default_nettype wire

// File: rtl/multi_mode_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_mode_queue_ctrl
// Purpose  : Control path of the multi-mode queue: enqueue/dequeue pointers,
//            occupancy count and the mode-dependent val/rdy/bypass logic.
// Ports    : clk, reset (async, active-low)
//            i_enq_val / o_enq_rdy   - input-side handshake
//            o_deq_val / i_deq_rdy   - output-side handshake
//            o_bypass_sel            - output mux selects the input message
//            o_write_en, o_write_ptr - storage write strobe and address
//            o_read_ptr              - storage read address (queue head)
//            o_num_free_entries      - empty entries remaining
// Revision : 1.0 - initial release
// ============================================================================
module multi_mode_queue_ctrl
  import multi_mode_queue_pkg::*;
#(
  parameter int p_type     = QUEUE_NORMAL,
  parameter int p_num_msgs = 4,
  parameter int PTR_NBITS  = ptr_nbits(p_num_msgs),
  parameter int CNT_NBITS  = $clog2(p_num_msgs + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enq_val,
  output logic                 o_enq_rdy,
  output logic                 o_deq_val,
  input  logic                 i_deq_rdy,
  output logic                 o_bypass_sel,
  output logic                 o_write_en,
  output logic [PTR_NBITS-1:0] o_write_ptr,
  output logic [PTR_NBITS-1:0] o_read_ptr,
  output logic [CNT_NBITS-1:0] o_num_free_entries
);

  localparam logic [CNT_NBITS-1:0] c_depth    = CNT_NBITS'(p_num_msgs);
  localparam logic [PTR_NBITS-1:0] c_last_ptr = PTR_NBITS'(p_num_msgs - 1);
  localparam bit c_pipe_en   = (p_type == QUEUE_PIPE)   || (p_type == QUEUE_PIPE_BYPASS);
  localparam bit c_bypass_en = (p_type == QUEUE_BYPASS) || (p_type == QUEUE_PIPE_BYPASS);

  logic [PTR_NBITS-1:0] r_enq_ptr;
  logic [PTR_NBITS-1:0] r_deq_ptr;
  logic [CNT_NBITS-1:0] r_count;

  logic  w_empty;
  logic  w_full;
  logic  w_bypass;
  logic  w_enq_fire;
  logic  w_deq_fire;
  logic  w_bypass_fire;
  logic  w_do_enq;
  logic  w_do_deq;
  xfer_e w_xfer;

  // Pointers wrap at the real depth, so non-power-of-2 depths work.
  function automatic logic [PTR_NBITS-1:0] next_ptr(input logic [PTR_NBITS-1:0] ptr);
    return (ptr == c_last_ptr) ? '0 : ptr + PTR_NBITS'(1);
  endfunction

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_depth);
  assign w_bypass = c_bypass_en && w_empty;

  // Both handshakes are forced low while reset is asserted so that nothing
  // completes during reset, including a bypass forward.
  assign o_enq_rdy = reset && (!w_full || (c_pipe_en && i_deq_rdy));
  assign o_deq_val = reset && (!w_empty || (w_bypass && i_enq_val));

  assign w_enq_fire    = i_enq_val && o_enq_rdy;
  assign w_deq_fire    = o_deq_val && i_deq_rdy;
  // A bypassed message goes straight through: no storage write, no pointer
  // or count movement.
  assign w_bypass_fire = w_bypass && w_deq_fire;
  assign w_do_enq      = w_enq_fire && !w_bypass_fire;
  assign w_do_deq      = w_deq_fire && !w_bypass_fire;
  assign w_xfer        = xfer_e'({w_do_enq, w_do_deq});

  assign o_bypass_sel       = w_bypass;
  assign o_write_en         = w_do_enq;
  assign o_write_ptr        = r_enq_ptr;
  assign o_read_ptr         = r_deq_ptr;
  assign o_num_free_entries = c_depth - r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enq_ptr <= '0;
      r_deq_ptr <= '0;
      r_count   <= '0;
    end else begin
      if (w_do_enq) r_enq_ptr <= next_ptr(r_enq_ptr);
      if (w_do_deq) r_deq_ptr <= next_ptr(r_deq_ptr);
      case (w_xfer)
        XFER_ENQ: r_count <= r_count + CNT_NBITS'(1);
        XFER_DEQ: r_count <= r_count - CNT_NBITS'(1);
        default:  r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Only a pipe-mode simultaneous dequeue may accompany an enqueue when full.
  a_no_overflow:  assert property (@(posedge clk) disable iff (!reset)
                                   (w_do_enq && !w_do_deq) |-> !w_full);
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
                                   w_do_deq |-> !w_empty);
  a_count_range:  assert property (@(posedge clk) disable iff (!reset)
                                   r_count <= c_depth);
`endif

endmodule
`default_nettype wire

// File: rtl/multi_mode_queue.sv
`default_nettype none
// ============================================================================
// Module   : multi_mode_queue
// Purpose  : Parametrised FIFO between val/rdy stages with a build-time mode:
//            normal, pipe (accept into a full queue while draining), bypass
//            (empty queue forwards combinationally) or pipe+bypass.
// Ports    : clk              - clock, rising edge
//            reset            - asynchronous active-low reset
//            istream          - enqueue stream (slave: val/msg in, rdy out)
//            ostream          - dequeue stream (master: val/msg out, rdy in)
//            num_free_entries - empty entries, for credit/flow control
// Revision : 1.0 - initial release
// ============================================================================
module multi_mode_queue
  import multi_mode_queue_pkg::*;
#(
  parameter int p_type      = QUEUE_NORMAL,
  parameter int p_msg_nbits = 32,
  parameter int p_num_msgs  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  multi_mode_queue_if.slave                 istream,
  multi_mode_queue_if.master                ostream,
  output logic [$clog2(p_num_msgs+1)-1:0]   num_free_entries
);

  localparam int PTR_NBITS = ptr_nbits(p_num_msgs);
  localparam int CNT_NBITS = $clog2(p_num_msgs + 1);

  if (p_type < QUEUE_NORMAL || p_type > QUEUE_PIPE_BYPASS) begin : g_bad_type
    $fatal(1, "multi_mode_queue: p_type must be 0..3");
  end
  if (p_msg_nbits < 1 || p_num_msgs < 1) begin : g_bad_size
    $fatal(1, "multi_mode_queue: p_msg_nbits and p_num_msgs must be >= 1");
  end

  logic                   w_enq_rdy;
  logic                   w_deq_val;
  logic                   w_bypass_sel;
  logic                   w_write_en;
  logic [PTR_NBITS-1:0]   w_write_ptr;
  logic [PTR_NBITS-1:0]   w_read_ptr;
  logic [CNT_NBITS-1:0]   w_num_free;

  // Storage is deliberately not reset: the count alone decides validity.
  logic [p_msg_nbits-1:0] r_storage [p_num_msgs];

  multi_mode_queue_ctrl #(
    .p_type     (p_type),
    .p_num_msgs (p_num_msgs),
    .PTR_NBITS  (PTR_NBITS),
    .CNT_NBITS  (CNT_NBITS)
  ) u_ctrl (
    .clk                (clk),
    .reset              (reset),
    .i_enq_val          (istream.val),
    .o_enq_rdy          (w_enq_rdy),
    .o_deq_val          (w_deq_val),
    .i_deq_rdy          (ostream.rdy),
    .o_bypass_sel       (w_bypass_sel),
    .o_write_en         (w_write_en),
    .o_write_ptr        (w_write_ptr),
    .o_read_ptr         (w_read_ptr),
    .o_num_free_entries (w_num_free)
  );

  // In pipe mode a full-queue write lands on the slot being vacated by the
  // same-cycle dequeue, since enq_ptr == deq_ptr when full.
  always_ff @(posedge clk) begin
    if (w_write_en) r_storage[w_write_ptr] <= istream.msg;
  end

  assign istream.rdy      = w_enq_rdy;
  assign ostream.val      = w_deq_val;
  assign ostream.msg      = w_bypass_sel ? istream.msg : r_storage[w_read_ptr];
  assign num_free_entries = w_num_free;

endmodule
`default_nettype wire

// File: tb/tb_multi_mode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_mode_queue
// Purpose  : Self-checking bench for multi_mode_queue in several builds:
//            normal/4, pipe/2, bypass/2, pipe+bypass/3 and normal/1.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_mode_queue;
  import multi_mode_queue_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  multi_mode_queue_if #(.p_msg_nbits(32)) n4_in (), n4_out ();
  multi_mode_queue_if #(.p_msg_nbits(32)) p2_in (), p2_out ();
  multi_mode_queue_if #(.p_msg_nbits(32)) b2_in (), b2_out ();
  multi_mode_queue_if #(.p_msg_nbits(32)) d3_in (), d3_out ();
  multi_mode_queue_if #(.p_msg_nbits(32)) d1_in (), d1_out ();

  logic [2:0] n4_free;
  logic [1:0] p2_free;
  logic [1:0] b2_free;
  logic [1:0] d3_free;
  logic [0:0] d1_free;

  multi_mode_queue #(.p_type(QUEUE_NORMAL), .p_msg_nbits(32), .p_num_msgs(4)) u_n4 (
    .clk(clk), .reset(reset), .istream(n4_in), .ostream(n4_out), .num_free_entries(n4_free));
  multi_mode_queue #(.p_type(QUEUE_PIPE), .p_msg_nbits(32), .p_num_msgs(2)) u_p2 (
    .clk(clk), .reset(reset), .istream(p2_in), .ostream(p2_out), .num_free_entries(p2_free));
  multi_mode_queue #(.p_type(QUEUE_BYPASS), .p_msg_nbits(32), .p_num_msgs(2)) u_b2 (
    .clk(clk), .reset(reset), .istream(b2_in), .ostream(b2_out), .num_free_entries(b2_free));
  multi_mode_queue #(.p_type(QUEUE_PIPE_BYPASS), .p_msg_nbits(32), .p_num_msgs(3)) u_d3 (
    .clk(clk), .reset(reset), .istream(d3_in), .ostream(d3_out), .num_free_entries(d3_free));
  multi_mode_queue #(.p_type(QUEUE_NORMAL), .p_msg_nbits(32), .p_num_msgs(1)) u_d1 (
    .clk(clk), .reset(reset), .istream(d1_in), .ostream(d1_out), .num_free_entries(d1_free));

  typedef struct {
    logic        val;
    logic [31:0] msg;
    logic        ordy;
    logic        e_irdy;
    logic        e_oval;
    logic [31:0] e_omsg;
    logic [2:0]  e_free;
  } vec_t;

  function automatic vec_t mk(input logic val, input logic [31:0] msg, input logic ordy,
                              input logic e_irdy, input logic e_oval,
                              input logic [31:0] e_omsg, input logic [2:0] e_free);
    vec_t v;
    v.val = val; v.msg = msg; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_oval = e_oval; v.e_omsg = e_omsg; v.e_free = e_free;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs[15];
  int   next_in, next_out, mcount;
  logic efire, dfire;

  initial begin
    {n4_in.val, p2_in.val, b2_in.val, d3_in.val, d1_in.val} = '0;
    {n4_out.rdy, p2_out.rdy, b2_out.rdy, d3_out.rdy, d1_out.rdy} = '0;
    n4_in.msg = '0; p2_in.msg = '0; b2_in.msg = '0; d3_in.msg = '0; d1_in.msg = '0;

    // ---------------- reset state (bypass input active during reset) ------
    b2_in.val = 1'b1; b2_in.msg = 32'h99; b2_out.rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.n4_irdy", n4_in.rdy, 0);
    check("rst.n4_oval", n4_out.val, 0);
    check("rst.n4_free", n4_free, 4);
    check("rst.b2_oval", b2_out.val, 0);
    check("rst.b2_irdy", b2_in.rdy, 0);
    check("rst.d3_free", d3_free, 3);
    b2_in.val = 1'b0; b2_out.rdy = 1'b0;
    reset = 1'b1;
    next_cycle();

    // ---------------- normal depth 4: table-driven -----------------------
    vecs[0]  = mk(1, 32'hA0, 0, 1, 0, 32'h0,  4);
    vecs[1]  = mk(1, 32'hA1, 0, 1, 1, 32'hA0, 3);
    vecs[2]  = mk(1, 32'hA2, 0, 1, 1, 32'hA0, 2);
    vecs[3]  = mk(1, 32'hA3, 0, 1, 1, 32'hA0, 1);
    vecs[4]  = mk(1, 32'hA4, 0, 0, 1, 32'hA0, 0);
    vecs[5]  = mk(0, 32'h0,  1, 0, 1, 32'hA0, 0);
    vecs[6]  = mk(0, 32'h0,  1, 1, 1, 32'hA1, 1);
    vecs[7]  = mk(0, 32'h0,  1, 1, 1, 32'hA2, 2);
    vecs[8]  = mk(0, 32'h0,  1, 1, 1, 32'hA3, 3);
    vecs[9]  = mk(0, 32'h0,  0, 1, 0, 32'h0,  4);
    vecs[10] = mk(1, 32'hB0, 0, 1, 0, 32'h0,  4);
    vecs[11] = mk(1, 32'hB1, 1, 1, 1, 32'hB0, 3);
    vecs[12] = mk(0, 32'h0,  0, 1, 1, 32'hB1, 3);
    vecs[13] = mk(0, 32'h0,  1, 1, 1, 32'hB1, 3);
    vecs[14] = mk(0, 32'h0,  0, 1, 0, 32'h0,  4);
    for (int i = 0; i < 15; i++) begin
      n4_in.val = vecs[i].val; n4_in.msg = vecs[i].msg; n4_out.rdy = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("n4[%0d].irdy", i), n4_in.rdy, vecs[i].e_irdy);
      check($sformatf("n4[%0d].oval", i), n4_out.val, vecs[i].e_oval);
      check($sformatf("n4[%0d].free", i), n4_free, vecs[i].e_free);
      if (vecs[i].e_oval) check($sformatf("n4[%0d].omsg", i), n4_out.msg, vecs[i].e_omsg);
      next_cycle();
    end
    n4_in.val = 1'b0; n4_out.rdy = 1'b0;

    // ---------------- pipe depth 2: enqueue into a full queue ------------
    p2_in.val = 1'b1; p2_in.msg = 32'h11; next_cycle();
    p2_in.msg = 32'h22; next_cycle();
    p2_in.msg = 32'h33; p2_out.rdy = 1'b0;
    @(negedge clk);
    check("p2.full_irdy", p2_in.rdy, 0);
    check("p2.full_free", p2_free, 0);
    p2_out.rdy = 1'b1; #1;
    check("p2.pipe_irdy", p2_in.rdy, 1);
    check("p2.pipe_omsg", p2_out.msg, 32'h11);
    next_cycle();
    p2_in.val = 1'b0; p2_out.rdy = 1'b0;
    @(negedge clk);
    check("p2.after_free", p2_free, 0);
    check("p2.second_omsg", p2_out.msg, 32'h22);
    p2_out.rdy = 1'b1; next_cycle(); p2_out.rdy = 1'b0;
    @(negedge clk);
    check("p2.third_omsg", p2_out.msg, 32'h33);
    check("p2.third_free", p2_free, 1);
    p2_out.rdy = 1'b1; next_cycle(); p2_out.rdy = 1'b0;
    @(negedge clk);
    check("p2.drained_oval", p2_out.val, 0);
    check("p2.drained_free", p2_free, 2);
    next_cycle();

    // ---------------- bypass depth 2 -------------------------------------
    b2_in.val = 1'b1; b2_in.msg = 32'h5A; b2_out.rdy = 1'b1;
    @(negedge clk);
    check("b2.byp_oval", b2_out.val, 1);
    check("b2.byp_omsg", b2_out.msg, 32'h5A);
    check("b2.byp_irdy", b2_in.rdy, 1);
    next_cycle();
    b2_in.val = 1'b0; b2_out.rdy = 1'b0;
    @(negedge clk);
    check("b2.byp_nostore_oval", b2_out.val, 0);
    check("b2.byp_nostore_free", b2_free, 2);
    b2_in.val = 1'b1; #1;
    check("b2.stall_oval", b2_out.val, 1);
    next_cycle();
    b2_in.val = 1'b0; b2_in.msg = 32'hFF;
    @(negedge clk);
    check("b2.stored_oval", b2_out.val, 1);
    check("b2.stored_omsg", b2_out.msg, 32'h5A);
    check("b2.stored_free", b2_free, 1);
    b2_out.rdy = 1'b1; next_cycle(); b2_out.rdy = 1'b0;
    @(negedge clk);
    check("b2.drained_free", b2_free, 2);
    next_cycle();

    // ---------------- depth 3 pipe+bypass stream, rdy toggling ------------
    next_in = 1; next_out = 1; mcount = 0;
    for (int cyc = 0; cyc < 60 && next_out <= 10; cyc++) begin
      d3_in.val = (next_in <= 10); d3_in.msg = 32'(next_in); d3_out.rdy = (cyc % 2 == 0);
      @(negedge clk);
      check($sformatf("d3[%0d].free", cyc), d3_free, 32'(3 - mcount));
      check($sformatf("d3[%0d].oval", cyc), d3_out.val, 32'((mcount > 0) || d3_in.val));
      check($sformatf("d3[%0d].irdy", cyc), d3_in.rdy, 32'((mcount < 3) || d3_out.rdy));
      efire = d3_in.val && d3_in.rdy;
      dfire = d3_out.val && d3_out.rdy;
      if (dfire) begin
        check($sformatf("d3[%0d].omsg", cyc), d3_out.msg, 32'(next_out));
        next_out++;
      end
      if (efire) next_in++;
      if (!(mcount == 0 && efire && dfire)) mcount = mcount + int'(efire) - int'(dfire);
      next_cycle();
    end
    d3_in.val = 1'b0; d3_out.rdy = 1'b0;
    check("d3.all_delivered", 32'(next_out), 11);
    @(negedge clk);
    check("d3.end_free", d3_free, 3);
    next_cycle();

    // ---------------- depth 1 normal: one transfer per two cycles ---------
    d1_in.val = 1'b1; d1_in.msg = 32'h7; d1_out.rdy = 1'b1;
    @(negedge clk);
    check("d1.c0_irdy", d1_in.rdy, 1);
    check("d1.c0_oval", d1_out.val, 0);
    next_cycle();
    d1_in.msg = 32'h8;
    @(negedge clk);
    check("d1.c1_irdy", d1_in.rdy, 0);
    check("d1.c1_omsg", d1_out.msg, 32'h7);
    check("d1.c1_free", d1_free, 0);
    next_cycle();
    @(negedge clk);
    check("d1.c2_irdy", d1_in.rdy, 1);
    check("d1.c2_oval", d1_out.val, 0);
    next_cycle();
    d1_in.val = 1'b0;
    @(negedge clk);
    check("d1.c3_oval", d1_out.val, 1);
    check("d1.c3_omsg", d1_out.msg, 32'h8);
    next_cycle();
    d1_out.rdy = 1'b0;
    @(negedge clk);
    check("d1.c4_free", d1_free, 1);
    next_cycle();

    // ---------------- asynchronous reset mid-operation --------------------
    n4_in.val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n4_in.msg = 32'hC0 + 32'(i);
      next_cycle();
    end
    n4_in.val = 1'b0;
    @(negedge clk);
    check("rstmid.pre_free", n4_free, 1);
    check("rstmid.pre_omsg", n4_out.msg, 32'hC0);
    #2 reset = 1'b0;
    #1;
    check("rstmid.oval", n4_out.val, 0);
    check("rstmid.free", n4_free, 4);
    check("rstmid.irdy", n4_in.rdy, 0);
    next_cycle();
    @(negedge clk);
    reset = 1'b1;
    n4_in.val = 1'b1; n4_in.msg = 32'hD0;
    next_cycle();
    n4_in.val = 1'b0;
    @(negedge clk);
    check("rstmid.first_oval", n4_out.val, 1);
    check("rstmid.first_omsg", n4_out.msg, 32'hD0);
    check("rstmid.first_free", n4_free, 3);
    n4_out.rdy = 1'b1; next_cycle(); n4_out.rdy = 1'b0;
    @(negedge clk);
    check("rstmid.empty_oval", n4_out.val, 0);
    check("rstmid.empty_free", n4_free, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
